// File: rtl/fk_planar_iter.sv
// Iterative planar-arm forward kinematics: one joint per clock, accumulating
// len*cos/sin of the running joint angle, then rounding and clamping to OUT_W.
`timescale 1ns/1ps
module fk_planar_iter #(
  parameter int unsigned N_JOINTS = 3,
  parameter int unsigned ANG_W    = 16,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned OUT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_JOINTS*ANG_W-1:0] theta,
  input  logic [N_JOINTS*LEN_W-1:0] len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          X,
  output logic [OUT_W-1:0]          Y,
  output logic                      out_err,
  output logic                      out_sat
);

  localparam int unsigned CW = (N_JOINTS > 1) ? $clog2(N_JOINTS) : 1;
  localparam int unsigned AW = LEN_W + 16 + $clog2(N_JOINTS) + 1;
  localparam int unsigned RW = ((AW > OUT_W) ? AW : OUT_W) + 1;
  localparam int unsigned PW = ANG_W + 2;

  localparam logic signed [PW-1:0] ANG_LIM = PW'(359);
  localparam logic signed [PW-1:0] P360    = PW'(360);
  localparam logic signed [AW-1:0] HALF    = AW'(8192);
  localparam logic signed [RW-1:0] MAXV    = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV    = ~MAXV;

  // round(16384*sin(d)), d = 0..90
  localparam int SIN_LUT [0:90] = '{
        0,   286,   572,   857,  1143,  1428,  1713,  1997,  2280,  2563,
     2845,  3126,  3406,  3686,  3964,  4240,  4516,  4790,  5063,  5334,
     5604,  5872,  6138,  6402,  6664,  6924,  7182,  7438,  7692,  7943,
     8192,  8438,  8682,  8923,  9162,  9397,  9630,  9860, 10087, 10311,
    10531, 10749, 10963, 11174, 11381, 11585, 11786, 11982, 12176, 12365,
    12551, 12733, 12911, 13085, 13255, 13421, 13583, 13741, 13894, 14044,
    14189, 14330, 14466, 14598, 14726, 14849, 14968, 15082, 15191, 15296,
    15396, 15491, 15582, 15668, 15749, 15826, 15897, 15964, 16026, 16083,
    16135, 16182, 16225, 16262, 16294, 16322, 16344, 16362, 16374, 16382,
    16384
  };

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, DONE} state_t;

  function automatic logic signed [16:0] sin_q(input logic [8:0] d);
    logic [6:0]         idx;
    logic               neg;
    logic signed [16:0] v;
    idx = '0;
    neg = 1'b0;
    if (d <= 9'd90) idx = 7'(d);
    else if (d <= 9'd180) idx = 7'(9'd180 - d);
    else if (d <= 9'd270) begin idx = 7'(d - 9'd180); neg = 1'b1; end
    else if (d <= 9'd359) begin idx = 7'(9'd360 - d); neg = 1'b1; end
    v = 17'(SIN_LUT[idx]);
    return neg ? -v : v;
  endfunction

  function automatic logic signed [16:0] cos_q(input logic [8:0] d);
    logic [9:0] t;
    t = {1'b0, d} + 10'd90;
    if (t >= 10'd360) t = t - 10'd360;
    return sin_q(9'(t));
  endfunction

  // Returns {saturated, value}: round half up at Q14, then clamp to OUT_W.
  function automatic logic [OUT_W:0] round_clamp(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    logic signed [RW-1:0] w;
    r = (a + HALF) >>> 14;
    w = RW'(r);
    if (w > MAXV) return {1'b1, MAXV[OUT_W-1:0]};
    else if (w < MINV) return {1'b1, MINV[OUT_W-1:0]};
    return {1'b0, w[OUT_W-1:0]};
  endfunction

  state_t                   state, state_n;
  logic [N_JOINTS*ANG_W-1:0] theta_q;
  logic [N_JOINTS*LEN_W-1:0] len_q;
  logic [8:0]               phi_q;
  logic [CW-1:0]            j;
  logic                     err_q;
  logic signed [AW-1:0]     acc_x, acc_y;

  logic                     err_in;
  logic signed [ANG_W-1:0]  th_chk, th_j;
  logic signed [LEN_W-1:0]  len_j;
  logic signed [PW-1:0]     phi_c;
  logic [8:0]               phi_n;
  logic signed [16:0]       cos_v, sin_v;
  logic signed [AW-1:0]     acc_x_n, acc_y_n;
  logic [OUT_W:0]           rc_x, rc_y;

  // Range check of every incoming joint angle
  always_comb begin
    err_in = 1'b0;
    th_chk = '0;
    for (int i = 0; i < int'(N_JOINTS); i++) begin
      th_chk = theta[i*ANG_W +: ANG_W];
      if (PW'(th_chk) > ANG_LIM || PW'(th_chk) < -ANG_LIM) err_in = 1'b1;
    end
  end

  // One joint step: wrap the running angle into 0..359 and accumulate
  always_comb begin
    th_j  = theta_q[j*ANG_W +: ANG_W];
    len_j = len_q[j*LEN_W +: LEN_W];
    phi_c = PW'($signed({1'b0, phi_q})) + PW'(th_j);
    if (phi_c[PW-1]) phi_c = phi_c + P360;
    else if (phi_c >= P360) phi_c = phi_c - P360;
    phi_n   = 9'(phi_c);
    cos_v   = cos_q(phi_n);
    sin_v   = sin_q(phi_n);
    acc_x_n = acc_x + AW'(len_j) * AW'(cos_v);
    acc_y_n = acc_y + AW'(len_j) * AW'(sin_v);
    rc_x    = round_clamp(acc_x);
    rc_y    = round_clamp(acc_y);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = ACCUM;
      ACCUM:   if (j == CW'(N_JOINTS - 1)) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_q <= '0;
      len_q   <= '0;
      phi_q   <= '0;
      j       <= '0;
      err_q   <= 1'b0;
      acc_x   <= '0;
      acc_y   <= '0;
      X       <= '0;
      Y       <= '0;
      out_err <= 1'b0;
      out_sat <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          theta_q <= theta;
          len_q   <= len;
          phi_q   <= '0;
          j       <= '0;
          err_q   <= err_in;
          acc_x   <= '0;
          acc_y   <= '0;
        end
        ACCUM: begin
          phi_q <= phi_n;
          acc_x <= acc_x_n;
          acc_y <= acc_y_n;
          j     <= j + CW'(1);
        end
        ROUND: begin
          X       <= err_q ? '0 : rc_x[OUT_W-1:0];
          Y       <= err_q ? '0 : rc_y[OUT_W-1:0];
          out_sat <= ~err_q & (rc_x[OUT_W] | rc_y[OUT_W]);
          out_err <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fk_planar_iter.sv
// Directed bench for fk_planar_iter: vector table on a 32-bit-output instance,
// plus stall, mid-operation reset and saturation sequences (16-bit-output instance).
`timescale 1ns/1ps
module tb_fk_planar_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err, out_sat;
  logic [47:0] theta, len;
  logic [31:0] x, y;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_err2, out_sat2;
  logic [47:0] theta2, len2;
  logic [15:0] x2, y2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fk_planar_iter #(.N_JOINTS(3), .ANG_W(16), .LEN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .theta(theta), .len(len), .out_valid(out_valid), .out_ready(out_ready),
    .X(x), .Y(y), .out_err(out_err), .out_sat(out_sat));

  fk_planar_iter #(.N_JOINTS(3), .ANG_W(16), .LEN_W(16), .OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .theta(theta2), .len(len2), .out_valid(out_valid2), .out_ready(out_ready2),
    .X(x2), .Y(y2), .out_err(out_err2), .out_sat(out_sat2));

  typedef struct {
    int t0, t1, t2;
    int l0, l1, l2;
    int ex, ey, eerr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int t0, t1, t2, l0, l1, l2, output int lat);
    int n;
    @(negedge clk);
    theta    = {16'(t2), 16'(t1), 16'(t0)};
    len      = {16'(l2), 16'(l1), 16'(l0)};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, "_valid_drop"}, longint'(out_valid), 0);
    check({name, "_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [31:0] xs, ys;

    vecs[0]  = '{0, 0, 0, 100, 100, 100, 300, 0, 0};
    vecs[1]  = '{90, 90, 90, 100, 100, 100, -100, 0, 0};
    vecs[2]  = '{-90, 0, 0, 100, 0, 0, 0, -100, 0};
    vecs[3]  = '{350, 20, 0, 0, 100, 0, 98, 17, 0};
    vecs[4]  = '{0, 400, 0, 100, 100, 100, 0, 0, 1};
    vecs[5]  = '{0, 0, 0, 100, 100, 100, 300, 0, 0};
    vecs[6]  = '{45, 0, 0, 100, 0, 0, 71, 71, 0};
    vecs[7]  = '{-359, 0, 0, 100, 0, 0, 100, 2, 0};
    vecs[8]  = '{359, 0, 0, 100, 0, 0, 100, -2, 0};
    vecs[9]  = '{-360, 0, 0, 100, 0, 0, 0, 0, 1};
    vecs[10] = '{30, 30, 30, 10, 10, 10, 14, 24, 0};
    vecs[11] = '{0, 0, 0, -50, 0, 0, -50, 0, 0};
    vecs[12] = '{180, 0, 0, 200, 0, 0, -200, 0, 0};
    vecs[13] = '{-180, -180, 0, 1, 1, 1, 1, 0, 0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; theta = '0; len = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; theta2 = '0; len2 = '0;
    #12;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_x", longint'($signed(x)), 0);
    check("rst_y", longint'($signed(y)), 0);
    check("rst_err", longint'(out_err), 0);
    check("rst_sat", longint'(out_sat), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].l0, vecs[i].l1, vecs[i].l2, lat);
      check($sformatf("v%0d_latency", i), longint'(lat), 4);
      check($sformatf("v%0d_x", i), longint'($signed(x)), longint'(vecs[i].ex));
      check($sformatf("v%0d_y", i), longint'($signed(y)), longint'(vecs[i].ey));
      check($sformatf("v%0d_err", i), longint'(out_err), longint'(vecs[i].eerr));
      check($sformatf("v%0d_sat", i), longint'(out_sat), 0);
      consume($sformatf("v%0d", i));
    end

    // Output stall: results hold, busy block ignores new requests
    send(0, 0, 0, 100, 100, 100, lat);
    check("stall_latency", longint'(lat), 4);
    xs = x;
    ys = y;
    check("stall_x0", longint'($signed(xs)), 300);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      theta    = {16'd90, 16'd90, 16'd90};
      in_valid = (k % 2 == 0);
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_x", k), longint'($signed(x)), longint'($signed(xs)));
      check($sformatf("stall%0d_y", k), longint'($signed(y)), longint'($signed(ys)));
      check($sformatf("stall%0d_in_ready", k), longint'(in_ready), 0);
      check($sformatf("stall%0d_out_valid", k), longint'(out_valid), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("stall");
    @(posedge clk);
    #1 check("stall_idle_in_ready", longint'(in_ready), 1);

    // Reset during ACCUM at j=1 discards the transaction
    @(negedge clk);
    theta = '0;
    len = {16'd100, 16'd100, 16'd100};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_x", longint'($signed(x)), 0);
    check("midrst_y", longint'($signed(y)), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", longint'(out_valid), 0);
    send(90, 90, 90, 100, 100, 100, lat);
    check("postrst_latency", longint'(lat), 4);
    check("postrst_x", longint'($signed(x)), -100);
    check("postrst_y", longint'($signed(y)), 0);
    consume("postrst");

    // Saturation on the 16-bit-output instance, both signs
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      theta2    = (s == 0) ? 48'd0 : {16'd0, 16'd0, 16'd180};
      len2      = {16'd32767, 16'd32767, 16'd32767};
      in_valid2 = 1'b1;
      n = 0;
      while (!in_ready2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1 in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("sat%0d_latency", s), longint'(n), 4);
      check($sformatf("sat%0d_x", s), longint'($signed(x2)), (s == 0) ? 32767 : -32768);
      check($sformatf("sat%0d_y", s), longint'($signed(y2)), 0);
      check($sformatf("sat%0d_flag", s), longint'(out_sat2), 1);
      check($sformatf("sat%0d_err", s), longint'(out_err2), 0);
      @(negedge clk);
      out_ready2 = 1'b1;
      @(posedge clk);
      #1 out_ready2 = 1'b0;
      check($sformatf("sat%0d_in_ready", s), longint'(in_ready2), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
